// File: rtl/aes_dec_round_ctrl_if.sv
// Control bundle between the AES decryption round sequencer and the
// column-serial datapath: start/abort/column handshake in, selects and
// strobes out.  The sequencer uses the slave view, the datapath side
// (or a bench standing in for it) uses the master view.
interface aes_dec_round_ctrl_if;
    logic       start;
    logic       abort;
    logic       col_ready;
    logic [3:0] Round;
    logic [1:0] counter_col;
    logic       load_state;
    logic       col_we;
    logic       state_swap;
    logic [3:0] key_addr;
    logic       last_round;
    logic       busy;
    logic       done;

    modport slave (
        input  start,
        input  abort,
        input  col_ready,
        output Round,
        output counter_col,
        output load_state,
        output col_we,
        output state_swap,
        output key_addr,
        output last_round,
        output busy,
        output done
    );

    modport master (
        output start,
        output abort,
        output col_ready,
        input  Round,
        input  counter_col,
        input  load_state,
        input  col_we,
        input  state_swap,
        input  key_addr,
        input  last_round,
        input  busy,
        input  done
    );
endinterface

// File: rtl/aes_dec_round_ctrl.sv
// Round sequencer for the column-serial AES-128 decryption datapath.
// Walks rounds 0..NROUNDS, one 32-bit column per accepted cycle, and
// decodes the state-register strobes from the FSM state.  Round keys are
// consumed in reverse order, so key_addr = NROUNDS - Round.
// NROUNDS must lie in 1..15 so that Round and key_addr fit in 4 bits.
module aes_dec_round_ctrl #(
    parameter int NROUNDS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_dec_round_ctrl_if.slave  bus
);

    localparam logic [3:0] LAST_RND = NROUNDS[3:0];

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ROUND  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    state_e     state_q;
    state_e     state_d;
    logic [3:0] round_q;
    logic [3:0] round_d;
    logic [1:0] col_q;
    logic [1:0] col_d;

    logic       load_state_s;
    logic       col_we_s;
    logic       state_swap_s;
    logic       busy_s;
    logic       done_s;

    // State, round and column registers; reset lands in IDLE with zeroed counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            round_q <= 4'd0;
            col_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            col_q   <= col_d;
        end
    end

    // Next-state and counter update; abort overrides everything and returns to a clean IDLE.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        col_d   = col_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
            round_d = 4'd0;
            col_d   = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    round_d = 4'd0;
                    col_d   = 2'd0;
                    if (bus.start) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    round_d = 4'd0;
                    col_d   = 2'd0;
                    state_d = ST_ROUND;
                end
                ST_ROUND: begin
                    if (bus.col_ready) begin
                        // Column 3 accepted: counter wraps to 0 and the round is committed.
                        col_d = col_q + 2'd1;
                        if (col_q == 2'd3) begin
                            state_d = ST_COMMIT;
                        end else begin
                            state_d = ST_ROUND;
                        end
                    end else begin
                        col_d   = col_q;
                        state_d = ST_ROUND;
                    end
                end
                ST_COMMIT: begin
                    col_d = 2'd0;
                    if (round_q == LAST_RND) begin
                        round_d = round_q;
                        state_d = ST_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = ST_ROUND;
                    end
                end
                ST_DONE: begin
                    // Round shows NROUNDS during DONE and is cleared on the way into IDLE.
                    round_d = 4'd0;
                    col_d   = 2'd0;
                    state_d = ST_IDLE;
                end
                default: begin
                    // Unused encodings recover to a clean IDLE.
                    round_d = 4'd0;
                    col_d   = 2'd0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Moore strobe decode; col_we additionally qualified by the downstream handshake.
    always_comb begin
        load_state_s = 1'b0;
        col_we_s     = 1'b0;
        state_swap_s = 1'b0;
        busy_s       = 1'b0;
        done_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_LOAD: begin
                load_state_s = 1'b1;
                busy_s       = 1'b1;
            end
            ST_ROUND: begin
                col_we_s = bus.col_ready;
                busy_s   = 1'b1;
            end
            ST_COMMIT: begin
                state_swap_s = 1'b1;
                busy_s       = 1'b1;
            end
            ST_DONE: begin
                done_s = 1'b1;
                busy_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign bus.Round       = round_q;
    assign bus.counter_col = col_q;
    assign bus.load_state  = load_state_s;
    assign bus.col_we      = col_we_s;
    assign bus.state_swap  = state_swap_s;
    assign bus.busy        = busy_s;
    assign bus.done        = done_s;
    // Reverse key schedule order; Round never exceeds NROUNDS so no wrap occurs.
    assign bus.key_addr    = LAST_RND - round_q;
    assign bus.last_round  = (round_q == LAST_RND);

endmodule
